cond_eval: RTL and testbench

Condition-code evaluator for the control unit. It reads the special-register flag outputs (N, Z, C, V, mode) and resolves 4-bit branch conditions for the instruction decoder over a valid/ready request and response handshake. It interlocks against in-flight flag writes, so every evaluation sees the flags produced by all earlier flag-setting instructions. It also keeps saturating statistics counters for debug.

---
 rtl/cond_eval.sv | 134 +++++++++++++
 tb/tb_cond_eval.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_eval.sv
// Condition-code evaluator: resolves 4-bit branch conditions against the NZCV/mode flags,
// stalling while a flag write is in flight. Optional macro COND_EVAL_MODE_COND_EN makes code 15 test mode_flag.
module cond_eval (
  input  logic        clock,
  input  logic        reset,
  input  logic        negative_flag,
  input  logic        zero_flag,
  input  logic        carry_flag,
  input  logic        overflow_flag,
  input  logic        mode_flag,
  input  logic        flag_write_pending,
  input  logic        req_valid,
  input  logic [3:0]  req_cond,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_taken,
  output logic [3:0]  resp_cond,
  output logic [15:0] eval_count,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [3:0] cond_r;
  logic       accept_s;
  logic       eval_s;
  logic [3:0] eval_code_s;
  logic       taken_s;
  logic       handshake_s;

  function automatic logic eval_cond(input logic [3:0] code, input logic n, input logic z,
                                     input logic c, input logic v, input logic m);
    case (code)
      4'd0:    eval_cond = z;
      4'd1:    eval_cond = ~z;
      4'd2:    eval_cond = c;
      4'd3:    eval_cond = ~c;
      4'd4:    eval_cond = n;
      4'd5:    eval_cond = ~n;
      4'd6:    eval_cond = v;
      4'd7:    eval_cond = ~v;
      4'd8:    eval_cond = c & ~z;
      4'd9:    eval_cond = ~c | z;
      4'd10:   eval_cond = (n == v);
      4'd11:   eval_cond = (n != v);
      4'd12:   eval_cond = ~z & (n == v);
      4'd13:   eval_cond = z | (n != v);
      4'd14:   eval_cond = 1'b1;
`ifdef COND_EVAL_MODE_COND_EN
      4'd15:   eval_cond = m;
`else
      // NV: never taken, mode_flag deliberately masked out
      4'd15:   eval_cond = m & 1'b0;
`endif
      default: eval_cond = 1'b0;
    endcase
  endfunction

  assign req_ready   = (state_r == IDLE) | ((state_r == RESP) & resp_ready);
  assign accept_s    = req_valid & req_ready;
  assign handshake_s = resp_valid & resp_ready;
  assign taken_s     = eval_cond(eval_code_s, negative_flag, zero_flag, carry_flag,
                                 overflow_flag, mode_flag);

  // Next-state and evaluate-strobe selection
  always_comb begin
    state_s     = state_r;
    eval_s      = 1'b0;
    eval_code_s = cond_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          eval_code_s = req_cond;
          if (flag_write_pending) begin
            state_s = WAIT;
          end else begin
            state_s = RESP;
            eval_s  = 1'b1;
          end
        end else if ((state_r == RESP) && !resp_ready) begin
          state_s = RESP;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (flag_write_pending) begin
          state_s = WAIT;
        end else begin
          state_s = RESP;
          eval_s  = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, latched request, registered response and saturating counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cond_r      <= 4'd0;
      resp_valid  <= 1'b0;
      resp_taken  <= 1'b0;
      resp_cond   <= 4'd0;
      eval_count  <= 16'd0;
      taken_count <= 16'd0;
    end else begin
      state_r    <= state_s;
      resp_valid <= (state_s == RESP);
      if (accept_s) begin
        cond_r <= req_cond;
      end
      if (eval_s) begin
        resp_taken <= taken_s;
        resp_cond  <= eval_code_s;
      end
      if (handshake_s && (eval_count != 16'hFFFF)) begin
        eval_count <= eval_count + 16'd1;
      end
      if (handshake_s && resp_taken && (taken_count != 16'hFFFF)) begin
        taken_count <= taken_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cond_eval.sv
// Randomized and directed bench for cond_eval against a transaction-level queue model.
module tb_cond_eval;

  logic        clock;
  logic        reset;
  logic        negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag;
  logic        flag_write_pending;
  logic        req_valid;
  logic [3:0]  req_cond;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [3:0]  resp_cond;
  logic [15:0] eval_count;
  logic [15:0] taken_count;

  cond_eval dut (
    .clock(clock), .reset(reset),
    .negative_flag(negative_flag), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .mode_flag(mode_flag),
    .flag_write_pending(flag_write_pending),
    .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_cond(resp_cond),
    .eval_count(eval_count), .taken_count(taken_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [3:0] cond;
    logic       taken;
  } resp_t;

  int         total = 0;
  int         bad = 0;
  logic [3:0] await_q[$];
  resp_t      resp_q[$];
  int         ev_cnt = 0;
  int         tk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs; odd codes invert the even partner.
  function automatic bit ref_taken(input int code, input bit n, input bit z, input bit c,
                                   input bit v, input bit m);
    bit base;
    if (code == 14) return 1'b1;
    if (code == 15) begin
`ifdef COND_EVAL_MODE_COND_EN
      return m;
`else
      return 1'b0;
`endif
    end
    case (code / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  task automatic set_flags(input logic [3:0] nzcv, input logic m);
    {negative_flag, zero_flag, carry_flag, overflow_flag} = nzcv;
    mode_flag = m;
  endtask

  // One clock: check req_ready, advance the model across the edge, then compare outputs.
  task automatic cycle();
    bit         exp_ready, acc, hs, pend, rst, t;
    logic [3:0] cin, c;
    bit         n, z, cy, v, m;
    resp_t      r;
    #2;
    exp_ready = (await_q.size() == 0 && resp_q.size() == 0) ||
                (resp_q.size() != 0 && resp_ready);
    if (!reset) check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    acc  = req_valid && exp_ready;
    hs   = (resp_q.size() != 0) && resp_ready;
    pend = flag_write_pending;
    rst  = reset;
    cin  = req_cond;
    n = negative_flag; z = zero_flag; cy = carry_flag; v = overflow_flag; m = mode_flag;
    @(posedge clock);
    #1;
    if (rst) begin
      await_q.delete();
      resp_q.delete();
      ev_cnt = 0;
      tk_cnt = 0;
    end else begin
      if (hs) begin
        r = resp_q.pop_front();
        if (ev_cnt < 65535) ev_cnt++;
        if (r.taken && tk_cnt < 65535) tk_cnt++;
      end
      if (acc) await_q.push_back(cin);
      if (await_q.size() != 0 && !pend) begin
        c = await_q.pop_front();
        t = ref_taken(int'(c), n, z, cy, v, m);
        resp_q.push_back('{cond: c, taken: t});
      end
    end
    check("resp_valid", {31'd0, resp_valid}, (resp_q.size() != 0) ? 32'd1 : 32'd0);
    if (resp_q.size() != 0) begin
      check("resp_taken", {31'd0, resp_taken}, {31'd0, resp_q[0].taken});
      check("resp_cond", {28'd0, resp_cond}, {28'd0, resp_q[0].cond});
    end
    check("eval_count", {16'd0, eval_count}, ev_cnt);
    check("taken_count", {16'd0, taken_count}, tk_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    flag_write_pending = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  int         stream_cnt;
  logic       saved_taken;
  logic [3:0] saved_cond;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_cond = 4'd0;
    resp_ready = 1'b0;
    flag_write_pending = 1'b0;
    set_flags(4'b0000, 1'b0);
    do_reset();
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_taken", {31'd0, resp_taken}, 32'd0);
    check("rst_cond", {28'd0, resp_cond}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // Basic EQ with Z=1
    set_flags(4'b0100, 1'b0);
    req_valid = 1'b1; req_cond = 4'd0; resp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    check("eq_valid", {31'd0, resp_valid}, 32'd1);
    check("eq_taken", {31'd0, resp_taken}, 32'd1);
    check("eq_cond", {28'd0, resp_cond}, 32'd0);
    cycle();
    check("eq_evcnt", {16'd0, eval_count}, 32'd1);
    check("eq_tkcnt", {16'd0, taken_count}, 32'd1);

    // Full sweep of codes x flags x mode, streamed
    resp_ready = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int f = 0; f < 16; f++)
        for (int c = 0; c < 16; c++) begin
          set_flags(f[3:0], m[0]);
          req_valid = 1'b1;
          req_cond = c[3:0];
          cycle();
        end
    drain();

    // Interlock: one pending cycle, flags change under the stall
    set_flags(4'b0000, 1'b0);
    req_valid = 1'b1; req_cond = 4'd0; flag_write_pending = 1'b1;
    cycle();
    check("il1_wait", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b0; flag_write_pending = 1'b0; set_flags(4'b0100, 1'b0);
    cycle();
    check("il1_valid", {31'd0, resp_valid}, 32'd1);
    check("il1_taken", {31'd0, resp_taken}, 32'd1);
    drain();

    // Interlock held three cycles
    req_valid = 1'b1; req_cond = 4'd1; flag_write_pending = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    check("il3_wait", {31'd0, resp_valid}, 32'd0);
    flag_write_pending = 1'b0; set_flags(4'b0000, 1'b0);
    cycle();
    check("il3_valid", {31'd0, resp_valid}, 32'd1);
    check("il3_taken", {31'd0, resp_taken}, 32'd1);
    drain();

    // Backpressure with a new request waiting
    set_flags(4'b1001, 1'b0);
    req_valid = 1'b1; req_cond = 4'd10; resp_ready = 1'b0;
    cycle();
    saved_taken = resp_taken;
    saved_cond = resp_cond;
    req_cond = 4'd11;
    for (int i = 0; i < 5; i++) begin
      set_flags(4'($urandom_range(0, 15)), 1'b0);
      cycle();
      check("bp_taken", {31'd0, resp_taken}, {31'd0, saved_taken});
      check("bp_cond", {28'd0, resp_cond}, 32'd10);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    cycle();
    check("bp_next", {28'd0, resp_cond}, 32'd11);
    drain();

    // Streaming 20 back-to-back requests
    stream_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      set_flags(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      req_valid = 1'b1; req_cond = 4'($urandom_range(0, 15));
      cycle();
      if (resp_valid === 1'b1) stream_cnt++;
    end
    check("stream_cnt", stream_cnt, 32'd20);
    drain();

    // Reset while waiting discards the request
    req_valid = 1'b1; req_cond = 4'd14; flag_write_pending = 1'b1;
    cycle();
    req_valid = 1'b0;
    do_reset();
    flag_write_pending = 1'b0;
    cycle();
    check("rstw_valid", {31'd0, resp_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_flags(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      req_valid = ($urandom_range(0, 9) < 6);
      req_cond = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 9) < 7);
      flag_write_pending = ($urandom_range(0, 9) < 3);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;
    drain();

    // Saturation with always-taken requests
    do_reset();
    req_valid = 1'b1; req_cond = 4'd14; resp_ready = 1'b1;
    for (int i = 0; i < 65541; i++) cycle();
    check("sat_ev", {16'd0, eval_count}, 32'hFFFF);
    check("sat_tk", {16'd0, taken_count}, 32'hFFFF);
    check("sat_valid", {31'd0, resp_valid}, 32'd1);
    do_reset();
    check("satrst_valid", {31'd0, resp_valid}, 32'd0);
    check("satrst_ev", {16'd0, eval_count}, 32'd0);
    check("satrst_tk", {16'd0, taken_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
